// File: rtl/error_code_pkg.sv
// Shared types for the error-code interface between error_code_processor,
// error_code_logger and their benches.
package error_code_pkg;

    typedef enum logic [3:0] {
        ERR_NONE       = 4'h0,
        ERR_OVERFLOW   = 4'h1,
        ERR_UNDERFLOW  = 4'h2,
        ERR_DIV_ZERO   = 4'h3,
        ERR_NEG_SQRT   = 4'h4,
        ERR_INVALID_OP = 4'h5,
        ERR_TIMEOUT    = 4'h6,
        ERR_UNKNOWN    = 4'hF
    } error_code_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_SQRT = 3'd5
    } op_e;

    localparam int LOG_HDR_W = 7;

    // The operation field stays plain logic: the processor may drive encodings outside op_e.
    typedef struct packed {
        logic [2:0]  op;
        error_code_e code;
    } log_hdr_t;

    function automatic logic is_event(input logic valid, input logic [3:0] code);
        return valid && (code != ERR_NONE);
    endfunction

endpackage

// File: rtl/error_log_fifo.sv
// Synchronous show-ahead FIFO for the error log; a push into a full FIFO is
// accepted when a pop in the same cycle frees the head slot.
module error_log_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 23,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop_ok   = pop && (count_q != '0) && !clear;
    assign push_ok  = push && !clear && (!full || pop_ok);
    assign overflow = push && !clear && full && !pop_ok;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; stale words are unreachable because head_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

    assign valid      = (count_q != '0);
    assign head_data  = valid ? mem[rd_ptr_q] : '0;
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/error_code_logger.sv
// Error-code consumer: timestamps and buffers non-zero codes for a host reader,
// keeps per-code counters, a seen-mask, a drop counter and a registered irq.
module error_code_logger
    import error_code_pkg::*;
#(
    parameter  int DEPTH      = 8,
    parameter  int TS_W       = 16,
    parameter  int CNT_W      = 8,
    parameter  int IRQ_THRESH = 4,
    localparam int LCNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      err_valid,
    input  logic [3:0]                error_code,
    input  logic [2:0]                operation,
    input  logic                      log_pop,
    output logic                      log_valid,
    output logic [LOG_HDR_W+TS_W-1:0] log_entry,
    output logic [LCNT_W-1:0]         log_count,
    output logic [7:0]                drop_count,
    input  logic [3:0]                sel_code,
    output logic [CNT_W-1:0]          code_count,
    output logic [15:0]               sticky_mask,
    output logic                      irq,
    input  logic                      clear
);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] cnt_q [16];
    logic [CNT_W-1:0] cnt_d [16];
    logic [15:0]      sticky_q, sticky_d;
    logic [7:0]       drop_q, drop_d;
    logic             fatal_q, fatal_d;
    logic             irq_q, irq_d;

    logic             evt;
    log_hdr_t         hdr;
    logic [LCNT_W-1:0] fifo_count_next;
    logic             fifo_overflow;

    // A clear cycle swallows the event entirely: no log, no count, no drop.
    assign evt      = is_event(err_valid, error_code) && !clear;
    assign hdr.op   = operation;
    assign hdr.code = error_code_e'(error_code);

    error_log_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LOG_HDR_W + TS_W)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .push       (evt),
        .push_data  ({hdr, ts_q}),
        .pop        (log_pop),
        .valid      (log_valid),
        .head_data  (log_entry),
        .count      (log_count),
        .count_next (fifo_count_next),
        .overflow   (fifo_overflow)
    );

    always_comb begin
        ts_d     = ts_q + 1'b1;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        drop_d   = drop_q;
        fatal_d  = fatal_q;
        if (clear) begin
            cnt_d    = '{default: '0};
            sticky_d = '0;
            drop_d   = '0;
            fatal_d  = 1'b0;
        end else if (evt) begin
            if (cnt_q[error_code] != {CNT_W{1'b1}}) begin
                cnt_d[error_code] = cnt_q[error_code] + 1'b1;
            end
            sticky_d[error_code] = 1'b1;
            if (error_code == ERR_UNKNOWN) fatal_d = 1'b1;
            if (fifo_overflow && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
        end
        irq_d = fatal_d | (fifo_count_next >= LCNT_W'(IRQ_THRESH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q     <= '0;
            cnt_q    <= '{default: '0};
            sticky_q <= '0;
            drop_q   <= '0;
            fatal_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ts_q     <= ts_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            drop_q   <= drop_d;
            fatal_q  <= fatal_d;
            irq_q    <= irq_d;
        end
    end

    assign code_count  = cnt_q[sel_code];
    assign sticky_mask = sticky_q;
    assign drop_count  = drop_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_error_code_logger.sv
// Directed bench for error_code_logger (DEPTH=8, TS_W=16, CNT_W=4, IRQ_THRESH=4).
module tb_error_code_logger;

    logic        clk;
    logic        reset_n;
    logic        err_valid;
    logic [3:0]  error_code;
    logic [2:0]  operation;
    logic        log_pop;
    logic        log_valid;
    logic [22:0] log_entry;
    logic [3:0]  log_count;
    logic [7:0]  drop_count;
    logic [3:0]  sel_code;
    logic [3:0]  code_count;
    logic [15:0] sticky_mask;
    logic        irq;
    logic        clear;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_ts;
    logic [15:0] t0, t1, t9, base;

    error_code_logger #(
        .DEPTH      (8),
        .TS_W       (16),
        .CNT_W      (4),
        .IRQ_THRESH (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .err_valid   (err_valid),
        .error_code  (error_code),
        .operation   (operation),
        .log_pop     (log_pop),
        .log_valid   (log_valid),
        .log_entry   (log_entry),
        .log_count   (log_count),
        .drop_count  (drop_count),
        .sel_code    (sel_code),
        .code_count  (code_count),
        .sticky_mask (sticky_mask),
        .irq         (irq),
        .clear       (clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One active edge, then settle away from it; exp_ts mirrors the free-running timestamp.
    task automatic tick();
        @(posedge clk);
        if (reset_n) exp_ts = exp_ts + 16'd1;
        #2;
    endtask

    initial begin
        reset_n    = 1'b0;
        err_valid  = 1'b0;
        error_code = 4'h0;
        operation  = 3'd0;
        log_pop    = 1'b0;
        sel_code   = 4'h0;
        clear      = 1'b0;
        exp_ts     = 16'd0;

        #3;
        check("rst_log_valid", log_valid, 0);
        check("rst_log_count", log_count, 0);
        check("rst_irq", irq, 0);
        check("rst_entry", log_entry, 0);
        #9;
        reset_n = 1'b1;
        exp_ts  = 16'd0;

        // Single event
        t0 = exp_ts;
        err_valid = 1'b1; error_code = 4'h1; operation = 3'b011; sel_code = 4'h1;
        tick();
        err_valid = 1'b0;
        check("t1_log_valid", log_valid, 1);
        check("t1_log_entry", log_entry, {3'b011, 4'h1, t0});
        check("t1_log_count", log_count, 1);
        check("t1_sticky", sticky_mask, 16'h0002);
        check("t1_code_count", code_count, 1);

        log_pop = 1'b1;
        tick();
        log_pop = 1'b0;
        check("t1_pop_count", log_count, 0);
        check("t1_pop_valid", log_valid, 0);
        check("t1_pop_entry", log_entry, 0);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_sticky", sticky_mask, 0);
        check("clr_code_count", code_count, 0);

        // ERR_NONE never logged or counted
        err_valid = 1'b1; error_code = 4'h0; operation = 3'd2;
        repeat (5) tick();
        err_valid = 1'b0;
        check("t2_log_count", log_count, 0);
        check("t2_sticky", sticky_mask, 0);
        check("t2_drop", drop_count, 0);
        check("t2_irq", irq, 0);
        check("t2_valid", log_valid, 0);

        // Fill past full: 9 events into 8 slots
        sel_code = 4'h4;
        base = exp_ts;
        for (int i = 0; i < 9; i++) begin
            err_valid = 1'b1; error_code = 4'h4; operation = 3'(i);
            tick();
        end
        err_valid = 1'b0;
        check("t3_full_count", log_count, 8);
        check("t3_drop", drop_count, 1);
        check("t3_code_count", code_count, 9);
        check("t3_head", log_entry, {3'd0, 4'h4, base});
        check("t3_irq", irq, 1);
        check("t3_sticky", sticky_mask, 16'h0010);

        // Event plus pop while full: accepted, no drop
        t9 = exp_ts;
        err_valid = 1'b1; error_code = 4'h4; operation = 3'd7; log_pop = 1'b1;
        tick();
        err_valid = 1'b0; log_pop = 1'b0;
        t1 = base + 16'd1;
        check("t3b_count", log_count, 8);
        check("t3b_drop", drop_count, 1);
        check("t3b_head", log_entry, {3'd1, 4'h4, t1});
        check("t3b_code_count", code_count, 10);

        log_pop = 1'b1;
        repeat (7) tick();
        log_pop = 1'b0;
        check("t3c_count", log_count, 1);
        check("t3c_tail", log_entry, {3'd7, 4'h4, t9});
        check("t3c_irq", irq, 0);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t3d_count", log_count, 0);
        check("t3d_drop", drop_count, 0);
        check("t3d_irq", irq, 0);

        // Occupancy threshold irq
        sel_code = 4'h2;
        for (int i = 0; i < 4; i++) begin
            err_valid = 1'b1; error_code = 4'h2; operation = 3'd1;
            tick();
            if (i == 2) begin
                check("t4_irq_below", irq, 0);
                check("t4_count3", log_count, 3);
            end
        end
        err_valid = 1'b0;
        check("t4_count4", log_count, 4);
        check("t4_irq_at", irq, 1);
        log_pop = 1'b1;
        tick();
        log_pop = 1'b0;
        check("t4_pop_count", log_count, 3);
        check("t4_pop_irq", irq, 0);

        // Fatal code keeps irq while draining
        err_valid = 1'b1; error_code = 4'hF; operation = 3'd5;
        tick();
        err_valid = 1'b0;
        check("t5_irq", irq, 1);
        check("t5_count", log_count, 4);
        check("t5_sticky", sticky_mask, 16'h8004);
        log_pop = 1'b1;
        repeat (4) tick();
        check("t5_drained", log_count, 0);
        check("t5_drained_valid", log_valid, 0);
        check("t5_drained_irq", irq, 1);
        tick();
        log_pop = 1'b0;
        check("t5_empty_pop", log_count, 0);
        check("t5_empty_pop_irq", irq, 1);

        // Clear beats a simultaneous event
        clear = 1'b1; err_valid = 1'b1; error_code = 4'h3; operation = 3'd0; sel_code = 4'h3;
        tick();
        clear = 1'b0; err_valid = 1'b0;
        check("t5c_irq", irq, 0);
        check("t5c_count", log_count, 0);
        check("t5c_sticky", sticky_mask, 0);
        check("t5c_code_count", code_count, 0);
        check("t5c_drop", drop_count, 0);

        // Counter saturation with streaming push+pop
        sel_code = 4'h5;
        t0 = 16'd0;
        for (int i = 0; i < 20; i++) begin
            t0 = exp_ts;
            err_valid = 1'b1; error_code = 4'h5; operation = 3'd2; log_pop = 1'b1;
            tick();
        end
        log_pop = 1'b0;
        check("t6_sat", code_count, 15);
        check("t6_count", log_count, 1);
        check("t6_head", log_entry, {3'd2, 4'h5, t0});
        repeat (2) tick();
        err_valid = 1'b0;
        check("t6_count3", log_count, 3);
        check("t6_sticky", sticky_mask, 16'h0020);

        // Asynchronous reset mid-stream
        #1;
        reset_n = 1'b0;
        #1;
        check("t6r_valid", log_valid, 0);
        check("t6r_count", log_count, 0);
        check("t6r_drop", drop_count, 0);
        check("t6r_sticky", sticky_mask, 0);
        check("t6r_irq", irq, 0);
        check("t6r_code_count", code_count, 0);
        check("t6r_entry", log_entry, 0);
        #3;
        reset_n = 1'b1;
        exp_ts  = 16'd0;
        t0 = exp_ts;
        err_valid = 1'b1; error_code = 4'h6; operation = 3'd4;
        tick();
        err_valid = 1'b0;
        check("t6p_count", log_count, 1);
        check("t6p_entry", log_entry, {3'd4, 4'h6, t0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
